// File: rtl/dds_pkg.sv
// Shared DDS control definitions: FTW width and limits, auto-repeat
// multipliers, and the debouncer state encoding.
package dds_pkg;

   localparam int          FTW_W         = 32;
   localparam logic [31:0] FTW_RESET_DEF = 32'd171798691;
   localparam logic [31:0] FTW_MIN_DEF   = 32'd85899;
   localparam logic [31:0] FTW_MAX_DEF   = 32'd171798691;

   // Auto-repeat timing, expressed in units of the debounce interval.
   localparam int RPT_DELAY_MULT  = 25;
   localparam int RPT_PERIOD_MULT = 5;

   typedef enum logic [1:0] {
      DB_IDLE    = 2'd0,
      DB_ARM     = 2'd1,
      DB_PRESSED = 2'd2,
      DB_REL     = 2'd3
   } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single active-low push-button: 2-FF synchroniser, debounce FSM and
// stability down-counter. Produces a one-cycle event per registered press.
// Build option FTW_TUNER_AUTOREPEAT_EN adds a hold-to-repeat counter.
//
// state      | meaning
// -----------+------------------------------------------------------
// DB_IDLE    | button released and stable; waiting for a low level
// DB_ARM     | low seen; counting DB_CYCLES of stable low
// DB_PRESSED | press registered (event emitted on entry)
// DB_REL     | high seen; counting DB_CYCLES of stable high
module btn_debounce
   import dds_pkg::*;
#(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_b,
   input  logic i_btn_n,
   output logic o_evt
);

   localparam int            CW       = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

   logic [1:0]    r_sync;
   db_state_t     r_state;
   db_state_t     w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          w_low;
   logic          w_cnt_tc;
   logic          w_press;
   logic          w_repeat;

   assign w_low    = ~r_sync[1];
   assign w_cnt_tc = (r_cnt == '0);

   // Two-flop synchroniser; resets to the released (high) level so a held
   // button must be seen fresh after reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], i_btn_n};
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_state <= DB_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DB_IDLE: begin
            if (w_low) w_state_nxt = DB_ARM;
         end
         DB_ARM: begin
            if (!w_low)        w_state_nxt = DB_IDLE;
            else if (w_cnt_tc) w_state_nxt = DB_PRESSED;
         end
         DB_PRESSED: begin
            if (!w_low) w_state_nxt = DB_REL;
         end
         DB_REL: begin
            if (w_low)         w_state_nxt = DB_PRESSED;
            else if (w_cnt_tc) w_state_nxt = DB_IDLE;
         end
         default: w_state_nxt = DB_IDLE;
      endcase
   end

   // Stability counter: reloaded on entry to ARM/REL, counts down while the
   // level holds and parks at terminal count.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_cnt <= '0;
      end else if ((r_state == DB_IDLE && w_low) || (r_state == DB_PRESSED && !w_low)) begin
         r_cnt <= CNT_LOAD;
      end else if (((r_state == DB_ARM && w_low) || (r_state == DB_REL && !w_low)) && !w_cnt_tc) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

`ifdef FTW_TUNER_AUTOREPEAT_EN
   localparam int            RW            = $clog2(RPT_DELAY_MULT * DB_CYCLES + 1);
   localparam logic [RW-1:0] RPT_DLY_LOAD  = RW'(RPT_DELAY_MULT * DB_CYCLES - 1);
   localparam logic [RW-1:0] RPT_PER_LOAD  = RW'(RPT_PERIOD_MULT * DB_CYCLES - 1);

   logic [RW-1:0] r_rpt;
   logic          w_rpt_tc;

   assign w_rpt_tc = (r_rpt == '0);

   // Repeat counter: initial delay armed by the press, then periodic while held.
   // A brief release (REL then back to PRESSED) keeps the current count.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_rpt <= '0;
      end else if (w_press) begin
         r_rpt <= RPT_DLY_LOAD;
      end else if (r_state == DB_PRESSED && w_low) begin
         r_rpt <= w_rpt_tc ? RPT_PER_LOAD : r_rpt - 1'b1;
      end
   end

   assign w_repeat = (r_state == DB_PRESSED) && w_low && w_rpt_tc;
`else
   assign w_repeat = 1'b0;
`endif

   // Output logic: event on the ARM->PRESSED transition, plus repeats.
   always_comb begin
      w_press = (r_state == DB_ARM) && w_low && w_cnt_tc;
      o_evt   = w_press | w_repeat;
   end

endmodule

// File: rtl/ftw_tuner.sv
// Debounced, saturating frequency-tuning-word controller for the DDS phase
// accumulator. N_STEP inc/dec button pairs each carry their own step; a host
// load presets the word. Any cycle with more than one button event is
// discarded. Build option FTW_TUNER_AUTOREPEAT_EN enables hold-to-repeat in
// the button debouncers.
module ftw_tuner
   import dds_pkg::*;
#(
   parameter int                  W          = FTW_W,
   parameter int                  N_STEP     = 3,
   parameter logic [W*N_STEP-1:0] STEP_TABLE = {32'd858993, 32'd85899, 32'd85},
   parameter logic [W-1:0]        FTW_RESET  = FTW_RESET_DEF,
   parameter logic [W-1:0]        FTW_MIN    = FTW_MIN_DEF,
   parameter logic [W-1:0]        FTW_MAX    = FTW_MAX_DEF,
   parameter int                  DB_CYCLES  = 500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_STEP-1:0] inc_n,
   input  logic [N_STEP-1:0] dec_n,
   input  logic              load,
   input  logic [W-1:0]      load_val,
   output logic [W-1:0]      ftw,
   output logic              ftw_valid,
   output logic              sat
);

   logic                r_rst_meta;
   logic                r_rst_sync;
   logic                w_rst_b;
   logic [N_STEP-1:0]   w_inc_evt;
   logic [N_STEP-1:0]   w_dec_evt;
   logic [2*N_STEP-1:0] w_evt_all;
   logic                w_evt_multi;
   logic                w_evt_single;
   logic                w_is_inc;
   logic [W-1:0]        w_step;
   logic [W:0]          w_sum;
   logic [W-1:0]        w_diff;
   logic [W-1:0]        w_ftw_nxt;
   logic                w_sat_nxt;
   logic                w_wr;
   logic [W-1:0]        r_ftw;
   logic                r_valid;
   logic                r_sat;

   // Reset synchroniser: assert asynchronously, release on the second clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_b = r_rst_sync;

   for (genvar gi = 0; gi < N_STEP; gi++) begin : g_btn
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc (
         .clk    (clk),
         .rst_b  (w_rst_b),
         .i_btn_n(inc_n[gi]),
         .o_evt  (w_inc_evt[gi])
      );
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec (
         .clk    (clk),
         .rst_b  (w_rst_b),
         .i_btn_n(dec_n[gi]),
         .o_evt  (w_dec_evt[gi])
      );
   end

   // Event arbitration: clearing the lowest set bit leaves anything only if
   // two or more events coincide.
   always_comb begin
      w_evt_all    = {w_dec_evt, w_inc_evt};
      w_evt_multi  = |(w_evt_all & (w_evt_all - 1'b1));
      w_evt_single = (|w_evt_all) && !w_evt_multi;
      w_is_inc     = |w_inc_evt;
   end

   // Step mux; only meaningful when exactly one event is present.
   always_comb begin
      w_step = '0;
      for (int i = 0; i < N_STEP; i++) begin
         if (w_inc_evt[i] || w_dec_evt[i]) w_step = w_step | STEP_TABLE[i*W +: W];
      end
   end

   // Next FTW: load beats a single button event; results are clamped exactly
   // so the register never holds an out-of-range value.
   always_comb begin
      w_sum     = {1'b0, r_ftw} + {1'b0, w_step};
      w_diff    = r_ftw - w_step;
      w_ftw_nxt = r_ftw;
      w_sat_nxt = r_sat;
      w_wr      = 1'b0;
      if (load) begin
         w_wr = 1'b1;
         if (load_val < FTW_MIN) begin
            w_ftw_nxt = FTW_MIN;
            w_sat_nxt = 1'b1;
         end else if (load_val > FTW_MAX) begin
            w_ftw_nxt = FTW_MAX;
            w_sat_nxt = 1'b1;
         end else begin
            w_ftw_nxt = load_val;
            w_sat_nxt = 1'b0;
         end
      end else if (w_evt_single) begin
         w_wr = 1'b1;
         if (w_is_inc) begin
            if (w_sum[W] || (w_sum > {1'b0, FTW_MAX})) begin
               w_ftw_nxt = FTW_MAX;
               w_sat_nxt = 1'b1;
            end else begin
               w_ftw_nxt = w_sum[W-1:0];
               w_sat_nxt = 1'b0;
            end
         end else begin
            if ((r_ftw < w_step) || (w_diff < FTW_MIN)) begin
               w_ftw_nxt = FTW_MIN;
               w_sat_nxt = 1'b1;
            end else begin
               w_ftw_nxt = w_diff;
               w_sat_nxt = 1'b0;
            end
         end
      end
   end

   // Output registers; ftw_valid marks every write, even a clamped no-change.
   always_ff @(posedge clk or negedge w_rst_b) begin
      if (!w_rst_b) begin
         r_ftw   <= FTW_RESET;
         r_sat   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_wr;
         if (w_wr) begin
            r_ftw <= w_ftw_nxt;
            r_sat <= w_sat_nxt;
         end
      end
   end

   assign ftw       = r_ftw;
   assign ftw_valid = r_valid;
   assign sat       = r_sat;

endmodule

// File: tb/tb_ftw_tuner.sv
// Scoreboard bench for ftw_tuner with DB_CYCLES=4 and default steps.
module tb_ftw_tuner;

   localparam int          W      = 32;
   localparam int          N      = 3;
   localparam logic [31:0] F_RST  = 32'd171798691;
   localparam logic [31:0] F_MIN  = 32'd85899;
   localparam logic [31:0] F_MAX  = 32'd171798691;

   typedef struct {
      logic [31:0] ftw;
      logic        sat;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] inc_n;
   logic [N-1:0] dec_n;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] ftw;
   logic         ftw_valid;
   logic         sat;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   n_spur  = 0;

   ftw_tuner #(.DB_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .inc_n    (inc_n),
      .dec_n    (dec_n),
      .load     (load),
      .load_val (load_val),
      .ftw      (ftw),
      .ftw_valid(ftw_valid),
      .sat      (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] f, input logic s);
      exp_t e;
      e.ftw = f;
      e.sat = s;
      sb.push_back(e);
   endtask

   // Every ftw_valid pulse consumes one expected write.
   always @(negedge clk) begin
      if (reset && ftw_valid) begin
         if (sb.size() == 0) begin
            n_spur++;
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_ftw", 64'(ftw), 64'(e.ftw));
            chk("sb_sat", 64'(sat), 64'(e.sat));
         end
      end
   end

   task automatic settle(input string tag, input logic [31:0] f, input logic s);
      repeat (3) @(negedge clk);
      chk({tag, "_pending"}, 64'(sb.size()), 64'd0);
      chk({tag, "_spurious"}, 64'(n_spur), 64'd0);
      chk({tag, "_ftw"}, 64'(ftw), 64'(f));
      chk({tag, "_sat"}, 64'(sat), 64'(s));
      sb.delete();
      n_spur = 0;
   endtask

   task automatic do_load(input logic [31:0] v, input logic [31:0] f, input logic s);
      push(f, s);
      load     = 1'b1;
      load_val = v;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic press(input bit is_inc, input int idx, input int hold);
      if (is_inc) inc_n[idx] = 1'b0;
      else        dec_n[idx] = 1'b0;
      repeat (hold) @(negedge clk);
      inc_n = '1;
      dec_n = '1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      logic [31:0] lv_in  [5];
      logic [31:0] lv_out [5];
      logic        lv_sat [5];
      int          n_rpt;

      reset    = 1'b1;
      inc_n    = '1;
      dec_n    = '1;
      load     = 1'b0;
      load_val = '0;

      // 1: reset
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ftw", 64'(ftw), 64'(F_RST));
      chk("rst_valid", 64'(ftw_valid), 64'd0);
      chk("rst_sat", 64'(sat), 64'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_ftw", 64'(ftw), 64'(F_RST));
      chk("post_rst_valid", 64'(ftw_valid), 64'd0);

      // load clamp boundaries
      lv_in  = '{32'd1000000, 32'hFFFF_FFFF, 32'd10, F_MAX, F_MIN};
      lv_out = '{32'd1000000, F_MAX,         F_MIN,  F_MAX, F_MIN};
      lv_sat = '{1'b0,        1'b1,          1'b1,   1'b0,  1'b0};
      for (int i = 0; i < 5; i++) begin
         do_load(lv_in[i], lv_out[i], lv_sat[i]);
         settle("load", lv_out[i], lv_sat[i]);
      end

      // 2: single inc, one pulse
      do_load(32'd1000000, 32'd1000000, 1'b0);
      push(32'd1085899, 1'b0);
      press(1'b1, 1, 10);
      settle("inc1", 32'd1085899, 1'b0);

      // 3: saturate high
      do_load(32'd171798000, 32'd171798000, 1'b0);
      push(F_MAX, 1'b1);
      press(1'b1, 2, 10);
      push(F_MAX, 1'b1);
      press(1'b1, 0, 10);
      settle("sat_hi", F_MAX, 1'b1);

      // 4: saturate low
      do_load(32'd100000, 32'd100000, 1'b0);
      push(F_MIN, 1'b1);
      press(1'b0, 1, 10);
      push(F_MIN, 1'b1);
      press(1'b0, 0, 10);
      settle("sat_lo", F_MIN, 1'b1);

      // 5: simultaneous events are dropped
      do_load(32'd1000000, 32'd1000000, 1'b0);
      inc_n[0] = 1'b0;
      dec_n[2] = 1'b0;
      repeat (10) @(negedge clk);
      inc_n = '1;
      dec_n = '1;
      repeat (12) @(negedge clk);
      settle("collide", 32'd1000000, 1'b0);

      // 6: bounce never registers
      for (int i = 0; i < 5; i++) begin
         inc_n[0] = 1'b0;
         repeat (3) @(negedge clk);
         inc_n[0] = 1'b1;
         @(negedge clk);
      end
      repeat (12) @(negedge clk);
      settle("bounce", 32'd1000000, 1'b0);

`ifdef FTW_TUNER_AUTOREPEAT_EN
      n_rpt = 1 + (140 - 4 - 100) / 20 + 1;
      for (int k = 1; k <= n_rpt; k++) push(32'd1000000 + 32'(85 * k), 1'b0);
      press(1'b1, 0, 140);
      settle("autorpt", 32'd1000255, 1'b0);
`else
      n_rpt = 1;
      push(32'd1000000 + 32'(85 * n_rpt), 1'b0);
      press(1'b1, 0, 140);
      settle("long_hold", 32'd1000085, 1'b0);
`endif

      // reset mid-debounce: pending press lost, held button re-registers once
      do_load(32'd1000000, 32'd1000000, 1'b0);
      settle("pre_rst", 32'd1000000, 1'b0);
      inc_n[0] = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_ftw", 64'(ftw), 64'(F_RST));
      chk("midrst_valid", 64'(ftw_valid), 64'd0);
      chk("midrst_sat", 64'(sat), 64'd0);
      reset = 1'b1;
      push(F_MAX, 1'b1);
      repeat (20) @(negedge clk);
      inc_n = '1;
      repeat (12) @(negedge clk);
      settle("midrst_evt", F_MAX, 1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
